bird_motion_ctrl: RTL and testbench
===================================

# bird_motion_ctrl

Per-frame motion controller for the bird sprite. Once per video frame it sequences the bird through idle, play, post-collision fall and dead. It integrates gravity and flap impulses into a vertical position, and derives the attitude code from velocity. Its outputs drive the sprite renderer's `bird_height`, `bird_angle`, `bird_valid` and `bird_color_select` inputs, and a `game_over` flag for the game-level logic.

## Interface
Parameters:
- `H_START`, 9'd200: height loaded at reset and on entering IDLE.
- `H_FLOOR`, 9'd448: lowest legal height (ground contact).
- `FLAP_V`, 6'd8: upward speed set by a flap, in pixels/frame.
- `GRAVITY`, 6'd1: velocity increment per frame.
- `V_MAX`, 6'd10: terminal downward velocity.

Ports:
- `clk` input 1: system/pixel clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `frame_tick` input 1: one-cycle pulse per frame (vsync-derived), synchronous to `clk`.
- `flap_btn` input 1: raw flap button level, asynchronous.
- `game_start` input 1: one-cycle pulse that starts a game.
- `collision` input 1: level from the pipe-overlap logic, sampled on `frame_tick`.
- `color_sel_in` input 3: bird colour choice, latched on start.
- `bird_height` output 9: bird top-edge coordinate; larger means lower on screen.
- `bird_angle` output 3: attitude code, 0..4.
- `bird_valid` output 1: sprite enable.
- `bird_color_select` output 3: latched colour.
- `game_over` output 1: high in DEAD.

## Operation
Flap input:
- `flap_btn` passes through a 2-FF synchronizer, followed by a rising-edge detect.
- A detected edge sets `flap_pend`.
- `flap_pend` is cleared on every `frame_tick`, whether or not it was consumed.

State machine, with transitions evaluated only on `frame_tick` unless noted:
- **IDLE**
  - Height is held at `H_START` and velocity at 0.
  - On a `game_start` pulse in any cycle: latch `color_sel_in`, clear `flap_pend`, go to PLAY.
- **PLAY**
  - If `collision`, go to FALL. Gravity is applied on this tick and the flap is ignored; collision wins over a simultaneous flap.
  - Otherwise, if `flap_pend`: `vel = -FLAP_V`.
  - Otherwise: `vel = min(vel + GRAVITY, V_MAX)`.
  - Then `height = height + vel_new`, clamped as described below.
- **FALL**
  - Gravity only; flaps are ignored.
  - Height is updated and clamped as in PLAY.
- **DEAD**
  - Entered from PLAY or FALL when the clamped height equals `H_FLOOR`.
  - Velocity is forced to 0 and height is held.
  - `game_over` = 1.
  - `game_start` returns to IDLE, reloading `H_START`.

Arithmetic:
- `vel` is 6-bit two's complement.
- The height sum is computed as an 11-bit signed value: `{2'b0,height} + sext(vel)`.
- If the sum < 0: `height` = 0 and `vel` = 0 (ceiling).
- If the sum >= `H_FLOOR`: `height` = `H_FLOOR` and the FSM goes to DEAD.

Angle, from the registered `vel`:
- `vel` <= -4 → 0
- -3..-1 → 1
- 0..2 → 2
- 3..5 → 3
- >= 6 → 4
- Codes 5..7 are never produced.

`bird_valid`:
- 1 in IDLE, PLAY and FALL.
- In DEAD it toggles every 16 frames, using a 4-bit frame counter cleared on entering DEAD.

`game_start` is ignored in PLAY and FALL.

## Timing
- All outputs are registered.
- State, `height`, `vel` and `angle` update on the clock edge at which `frame_tick` is sampled high, so they are visible in the cycle after the tick.
- `bird_angle` reflects the new velocity in the same cycle as the new height.
- Flap latency:
  - A `flap_btn` rising edge sets `flap_pend` 3 clocks later (2 sync stages plus the edge register).
  - The flap acts on the first `frame_tick` after that.
  - An edge landing in the same cycle as the tick misses that frame.
- `game_start` takes effect on the next clock edge, independent of `frame_tick`.
- Reset values: state IDLE, `bird_height` = `H_START`, `vel` = 0, `bird_angle` = 2, `bird_valid` = 1, `bird_color_select` = 0, `game_over` = 0, `flap_pend` = 0, synchronizer = 0.
- Reset asserted mid-game returns every output to its reset value immediately and asynchronously.

## Test plan
- **Reset state:** reset, then start, no flaps, 3 ticks → `bird_height` 201, 203, 206; `bird_angle` 2, 2, 3.
- **Flap:** in PLAY at height 206 with `vel` 3, pulse `flap_btn`, then tick → height 198, `vel` -8, angle 0. Next tick → 191, angle 0.
- **Ceiling:** height 5, flap, tick → height 0, `vel` 0, angle 2. The following tick → height 1.
- **Terminal velocity and floor:**
  - After 10 ticks without a flap, `vel` saturates at 10 and stays there.
  - Once height + 10 >= 448 → `bird_height` = 448, `game_over` = 1, `bird_valid` toggles after 16 ticks.
  - `game_start` → IDLE with height 200.
- **Collision with flap on the same tick:** `collision` = 1 with `flap_pend` set → FALL, gravity applied (`vel` +1), and later flaps have no effect until the floor.
- **Start ignored, then reset:** `game_start` pulses during PLAY are ignored. Asserting `rst_n` low mid-FALL → height 200, state IDLE, `game_over` 0 in the same cycle.

Source files
------------

// File: rtl/bird_motion_ctrl.sv
// Per-frame motion controller for the bird sprite: sequences idle/play/fall/dead,
// integrates gravity and flap impulses into a vertical position and derives the
// attitude code from the vertical velocity.
//
// state | meaning
// IDLE  | waiting for game_start, height parked at H_START
// PLAY  | gravity + flaps applied once per frame
// FALL  | post-collision drop, gravity only
// DEAD  | on the floor, game_over high, sprite blinks every 16 frames
module bird_motion_ctrl #(
  parameter logic [8:0] H_START = 9'd200,
  parameter logic [8:0] H_FLOOR = 9'd448,
  parameter logic [5:0] FLAP_V  = 6'd8,
  parameter logic [5:0] GRAVITY = 6'd1,
  parameter logic [5:0] V_MAX   = 6'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       flap_btn,
  input  logic       game_start,
  input  logic       collision,
  input  logic [2:0] color_sel_in,
  output logic [8:0] bird_height,
  output logic [2:0] bird_angle,
  output logic       bird_valid,
  output logic [2:0] bird_color_select,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_FALL = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  state_t            state;
  logic        [5:0] vel;
  logic              flap_pend;
  logic        [1:0] flap_sync;
  logic              flap_prev;
  logic              flap_edge;
  logic        [3:0] blink_cnt;

  logic signed [7:0]  grav_sum;
  logic signed [7:0]  vel_cand;
  logic signed [10:0] h_sum;
  logic        [5:0]  vel_next;
  logic        [8:0]  h_next;
  logic               hit_floor;
  logic               use_flap;

  // Attitude code from a signed 6-bit velocity (negative = climbing).
  function automatic logic [2:0] angle_of(input logic signed [5:0] v);
    logic [2:0] a;
    if (v <= -6'sd4)      a = 3'd0;
    else if (v <= -6'sd1) a = 3'd1;
    else if (v <= 6'sd2)  a = 3'd2;
    else if (v <= 6'sd5)  a = 3'd3;
    else                  a = 3'd4;
    return a;
  endfunction

  // Two-stage synchronizer on the raw button plus a delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flap_sync <= 2'b00;
      flap_prev <= 1'b0;
    end else begin
      flap_sync <= {flap_sync[0], flap_btn};
      flap_prev <= flap_sync[1];
    end
  end

  assign flap_edge = flap_sync[1] & ~flap_prev;

  // Next velocity and clamped height for the current frame; collision beats a flap.
  always_comb begin
    use_flap  = (state == ST_PLAY) && !collision && flap_pend;
    grav_sum  = $signed({{2{vel[5]}}, vel}) + $signed({2'b00, GRAVITY});
    if (grav_sum > $signed({2'b00, V_MAX}))
      vel_cand = $signed({2'b00, V_MAX});
    else
      vel_cand = grav_sum;
    if (use_flap)
      vel_cand = -$signed({2'b00, FLAP_V});
    h_sum     = $signed({2'b00, bird_height}) + $signed({{3{vel_cand[7]}}, vel_cand});
    hit_floor = 1'b0;
    if (h_sum[10]) begin
      h_next   = 9'd0;
      vel_next = 6'd0;
    end else if (h_sum >= $signed({2'b00, H_FLOOR})) begin
      h_next    = H_FLOOR;
      vel_next  = 6'd0;
      hit_floor = 1'b1;
    end else begin
      h_next   = h_sum[8:0];
      vel_next = vel_cand[5:0];
    end
  end

  // Game-state sequencer with registered sprite outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      bird_height       <= H_START;
      vel               <= 6'd0;
      bird_angle        <= 3'd2;
      bird_valid        <= 1'b1;
      bird_color_select <= 3'd0;
      game_over         <= 1'b0;
      flap_pend         <= 1'b0;
      blink_cnt         <= 4'd0;
    end else begin
      // A tick always drains the pending flap, so an edge coinciding with a tick is lost.
      if (frame_tick)
        flap_pend <= 1'b0;
      else if (flap_edge)
        flap_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          bird_height <= H_START;
          vel         <= 6'd0;
          bird_angle  <= 3'd2;
          bird_valid  <= 1'b1;
          game_over   <= 1'b0;
          if (game_start) begin
            bird_color_select <= color_sel_in;
            flap_pend         <= 1'b0;
            state             <= ST_PLAY;
          end
        end
        ST_PLAY, ST_FALL: begin
          if (frame_tick) begin
            bird_height <= h_next;
            vel         <= vel_next;
            bird_angle  <= angle_of(vel_next);
            if (hit_floor) begin
              state      <= ST_DEAD;
              game_over  <= 1'b1;
              bird_valid <= 1'b1;
              blink_cnt  <= 4'd0;
            end else if (state == ST_PLAY && collision) begin
              state <= ST_FALL;
            end
          end
        end
        ST_DEAD: begin
          if (game_start) begin
            state       <= ST_IDLE;
            bird_height <= H_START;
            vel         <= 6'd0;
            bird_angle  <= 3'd2;
            bird_valid  <= 1'b1;
            game_over   <= 1'b0;
          end else if (frame_tick) begin
            blink_cnt <= blink_cnt + 4'd1;
            if (blink_cnt == 4'd15)
              bird_valid <= ~bird_valid;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Bench for bird_motion_ctrl: directed table and sequences with constant
// expectations, plus random stimulus checked every cycle against a frame-level model.
module tb_bird_motion_ctrl;

  localparam int H_START = 200;
  localparam int H_FLOOR = 448;
  localparam int FLAP_V  = 8;
  localparam int GRAV    = 1;
  localparam int V_MAX   = 10;

  localparam int S_IDLE = 0;
  localparam int S_PLAY = 1;
  localparam int S_FALL = 2;
  localparam int S_DEAD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       flap_btn = 1'b0;
  logic       game_start = 1'b0;
  logic       collision = 1'b0;
  logic [2:0] color_sel_in = 3'd0;
  logic [8:0] bird_height;
  logic [2:0] bird_angle;
  logic       bird_valid;
  logic [2:0] bird_color_select;
  logic       game_over;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  bird_motion_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_tick        (frame_tick),
    .flap_btn          (flap_btn),
    .game_start        (game_start),
    .collision         (collision),
    .color_sel_in      (color_sel_in),
    .bird_height       (bird_height),
    .bird_angle        (bird_angle),
    .bird_valid        (bird_valid),
    .bird_color_select (bird_color_select),
    .game_over         (game_over)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int       st;
    int       h;
    int       v;
    bit       pend;
    int       color;
    int       dead_ticks;
    bit [2:0] hist;   // button samples at the previous 1, 2, 3 clock edges
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = S_IDLE; r.h = H_START; r.v = 0; r.pend = 1'b0;
    r.color = 0; r.dead_ticks = 0; r.hist = 3'b000;
    return r;
  endfunction

  function automatic int angle_of(int v);
    if (v <= -4) return 0;
    if (v <= -1) return 1;
    if (v <= 2)  return 2;
    if (v <= 5)  return 3;
    return 4;
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic mdl_t mdl_next(mdl_t c, bit tick, bit btn, bit start, bit coll, int col);
    mdl_t n;
    bit   edge_now;
    int   v;
    int   s;
    n = c;
    // rising edge seen by the controller two edges after the button was sampled
    edge_now = c.hist[1] & ~c.hist[2];
    n.hist = {c.hist[1], c.hist[0], btn};
    n.pend = tick ? 1'b0 : (edge_now ? 1'b1 : c.pend);
    case (c.st)
      S_IDLE: begin
        n.h = H_START; n.v = 0;
        if (start) begin n.color = col; n.pend = 1'b0; n.st = S_PLAY; end
      end
      S_PLAY, S_FALL: begin
        if (tick) begin
          if (c.st == S_PLAY && !coll && c.pend) v = -FLAP_V;
          else v = min_i(c.v + GRAV, V_MAX);
          s = c.h + v;
          if (s >= H_FLOOR) begin
            n.h = H_FLOOR; n.v = 0; n.st = S_DEAD; n.dead_ticks = 0;
          end else begin
            if (s < 0) begin n.h = 0; n.v = 0; end
            else begin n.h = s; n.v = v; end
            if (c.st == S_PLAY && coll) n.st = S_FALL;
          end
        end
      end
      default: begin
        if (start) begin n.st = S_IDLE; n.h = H_START; n.v = 0; end
        else if (tick) n.dead_ticks = c.dead_ticks + 1;
      end
    endcase
    return n;
  endfunction

  // model advances on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else m <= mdl_next(m, frame_tick, flap_btn, game_start, collision, int'(color_sel_in));
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle, compare all outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("mdl_height", int'(bird_height), m.h);
      chk("mdl_angle", int'(bird_angle), angle_of(m.v));
      chk("mdl_valid", int'(bird_valid),
          ((m.st != S_DEAD) || (((m.dead_ticks / 16) % 2) == 0)) ? 1 : 0);
      chk("mdl_color", int'(bird_color_select), m.color);
      chk("mdl_game_over", int'(game_over), (m.st == S_DEAD) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame(input bit flap, input bit coll);
    if (flap) begin
      flap_btn = 1'b1;
      @(negedge clk); @(negedge clk);
      flap_btn = 1'b0;
      repeat (4) @(negedge clk);
    end
    collision  = coll;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    collision  = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] col);
    color_sel_in = col;
    game_start   = 1'b1;
    @(negedge clk);
    game_start   = 1'b0;
  endtask

  typedef struct {
    bit flap;
    bit coll;
    int exp_h;
    int exp_angle;
    bit exp_go;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int h;
    int v;
    vecs[0] = '{flap: 1'b0, coll: 1'b0, exp_h: 201, exp_angle: 2, exp_go: 1'b0};
    vecs[1] = '{flap: 1'b0, coll: 1'b0, exp_h: 203, exp_angle: 2, exp_go: 1'b0};
    vecs[2] = '{flap: 1'b0, coll: 1'b0, exp_h: 206, exp_angle: 3, exp_go: 1'b0};
    vecs[3] = '{flap: 1'b1, coll: 1'b0, exp_h: 198, exp_angle: 0, exp_go: 1'b0};
    vecs[4] = '{flap: 1'b0, coll: 1'b0, exp_h: 191, exp_angle: 0, exp_go: 1'b0};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_height", int'(bird_height), 200);
    chk("rst_angle", int'(bird_angle), 2);
    chk("rst_valid", int'(bird_valid), 1);
    chk("rst_color", int'(bird_color_select), 0);
    chk("rst_game_over", int'(game_over), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    repeat (2) @(negedge clk);

    // start, three gravity frames, flap, gravity
    pulse_start(3'd5);
    chk("start_color", int'(bird_color_select), 5);
    for (int i = 0; i < 5; i++) begin
      frame(vecs[i].flap, vecs[i].coll);
      chk($sformatf("vec%0d_height", i), int'(bird_height), vecs[i].exp_h);
      chk($sformatf("vec%0d_angle", i), int'(bird_angle), vecs[i].exp_angle);
      chk($sformatf("vec%0d_game_over", i), int'(game_over), int'(vecs[i].exp_go));
    end

    // climb with a flap every frame until the ceiling clamps
    for (int k = 1; k <= 23; k++) begin
      frame(1'b1, 1'b0);
      chk("climb_height", int'(bird_height), 191 - 8 * k);
    end
    frame(1'b1, 1'b0);
    chk("ceil_height", int'(bird_height), 0);
    chk("ceil_angle", int'(bird_angle), 2);
    frame(1'b0, 1'b0);
    chk("ceil_next_height", int'(bird_height), 1);
    chk("ceil_next_angle", int'(bird_angle), 2);

    // free fall to terminal velocity and the floor
    h = 1; v = 1;
    for (int k = 0; k < 60 && h < H_FLOOR; k++) begin
      frame(1'b0, 1'b0);
      v = min_i(v + 1, 10);
      h = h + v;
      if (h >= H_FLOOR) begin
        chk("floor_height", int'(bird_height), 448);
        chk("floor_game_over", int'(game_over), 1);
        chk("floor_angle", int'(bird_angle), 2);
      end else begin
        chk("fall_height", int'(bird_height), h);
        chk("fall_angle", int'(bird_angle), (v >= 6) ? 4 : ((v >= 3) ? 3 : 2));
      end
    end
    for (int k = 1; k <= 16; k++) begin
      frame(k == 5, 1'b0);
      chk("dead_valid", int'(bird_valid), (k < 16) ? 1 : 0);
      chk("dead_height", int'(bird_height), 448);
    end
    pulse_start(3'd1);
    chk("restart_height", int'(bird_height), 200);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_valid", int'(bird_valid), 1);

    // collision on the same tick as a pending flap
    pulse_start(3'd3);
    chk("coll_color", int'(bird_color_select), 3);
    frame(1'b0, 1'b0);
    chk("coll_pre_height", int'(bird_height), 201);
    frame(1'b1, 1'b1);
    chk("coll_height", int'(bird_height), 203);
    chk("coll_angle", int'(bird_angle), 2);
    frame(1'b1, 1'b0);
    chk("fall_flap_height", int'(bird_height), 206);
    chk("fall_flap_angle", int'(bird_angle), 3);
    pulse_start(3'd6);
    chk("fall_start_height", int'(bird_height), 206);
    chk("fall_start_color", int'(bird_color_select), 3);
    frame(1'b0, 1'b0);
    chk("fall_height2", int'(bird_height), 210);

    // asynchronous reset mid-fall
    #2 rst_n = 1'b0;
    #1;
    chk("arst_height", int'(bird_height), 200);
    chk("arst_game_over", int'(game_over), 0);
    chk("arst_angle", int'(bird_angle), 2);
    chk("arst_color", int'(bird_color_select), 0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(1'b0, 1'b0);
    chk("arst_idle_height", int'(bird_height), 200);

    // flap edge reaching the controller on the tick edge misses that frame
    pulse_start(3'd2);
    frame(1'b0, 1'b0);
    chk("lat_pre_height", int'(bird_height), 201);
    flap_btn = 1'b1;
    @(negedge clk); @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    flap_btn   = 1'b0;
    chk("lat_miss_height", int'(bird_height), 203);
    frame(1'b0, 1'b0);
    chk("lat_miss_next", int'(bird_height), 206);
    flap_btn = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    flap_btn   = 1'b0;
    chk("lat_hit_height", int'(bird_height), 198);
    chk("lat_hit_angle", int'(bird_angle), 0);

    // random stimulus against the model
    for (int c = 0; c < 6000; c++) begin
      frame_tick   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) flap_btn = ~flap_btn;
      game_start   = ($urandom_range(0, 80) == 0);
      if ($urandom_range(0, 30) == 0) collision = ~collision;
      color_sel_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    frame_tick = 1'b0;
    game_start = 1'b0;
    collision  = 1'b0;
    @(negedge clk);
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
